// File: rtl/oled_power_seq.sv
// OLED panel power sequencer: walks a fixed step table (pin, delay, SPI command)
// to bring the panel up to ON and back down to OFF.
module oled_power_seq #(
    parameter logic [11:0] T_VDD_MS  = 12'd1,
    parameter logic [11:0] T_RES_MS  = 12'd1,
    parameter logic [11:0] T_VBAT_MS = 12'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_on_req,
    input  logic        power_off_req,
    output logic        delay_start,
    output logic [11:0] delay_time_ms,
    input  logic        delay_done,
    output logic        spi_start,
    output logic [7:0]  spi_data,
    input  logic        spi_done,
    output logic        vdd_n,
    output logic        vbat_n,
    output logic        res_n,
    output logic        dc,
    output logic        ready
);

    localparam int unsigned STEP_W = 5;
    localparam int unsigned ARG_W  = 12;

    // Step kinds
    localparam logic [2:0] K_PIN     = 3'd0;
    localparam logic [2:0] K_DLY     = 3'd1;
    localparam logic [2:0] K_SPI     = 3'd2;
    localparam logic [2:0] K_END_ON  = 3'd3;
    localparam logic [2:0] K_END_OFF = 3'd4;

    // PIN step argument: bit 2 = new level, bits 1:0 = pin select
    localparam logic [1:0] PIN_VDD  = 2'd0;
    localparam logic [1:0] PIN_RES  = 2'd1;
    localparam logic [1:0] PIN_VBAT = 2'd2;

    // First step of the power-down table
    localparam logic [STEP_W-1:0] STEP_DOWN = STEP_W'(19);

    typedef enum logic [2:0] {
        S_OFF,
        S_FETCH,
        S_DLY_REQ,
        S_DLY_WAIT,
        S_SPI_REQ,
        S_SPI_WAIT,
        S_ON
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic                r_pend_off;
    logic                w_pend_off_nxt;
    logic                r_wait_first;

    logic [2:0]          w_kind;
    logic [ARG_W-1:0]    w_arg;

    logic                r_delay_start;
    logic [11:0]         r_delay_time_ms;
    logic                r_spi_start;
    logic [7:0]          r_spi_data;
    logic                r_vdd_n;
    logic                r_vbat_n;
    logic                r_res_n;
    logic                r_ready;

    logic                w_delay_start_nxt;
    logic [11:0]         w_delay_time_ms_nxt;
    logic                w_spi_start_nxt;
    logic [7:0]          w_spi_data_nxt;
    logic                w_vdd_n_nxt;
    logic                w_vbat_n_nxt;
    logic                w_res_n_nxt;
    logic                w_ready_nxt;

    // Step table decode: power-up occupies steps 0..18, power-down 19..23
    always_comb begin
        w_kind = K_END_OFF;
        w_arg  = '0;
        case (r_step)
            5'd0:  begin w_kind = K_PIN;    w_arg = {9'd0, 1'b0, PIN_VDD};  end
            5'd1:  begin w_kind = K_DLY;    w_arg = T_VDD_MS;               end
            5'd2:  begin w_kind = K_SPI;    w_arg = 12'h0AE;                end
            5'd3:  begin w_kind = K_PIN;    w_arg = {9'd0, 1'b0, PIN_RES};  end
            5'd4:  begin w_kind = K_DLY;    w_arg = T_RES_MS;               end
            5'd5:  begin w_kind = K_PIN;    w_arg = {9'd0, 1'b1, PIN_RES};  end
            5'd6:  begin w_kind = K_DLY;    w_arg = T_RES_MS;               end
            5'd7:  begin w_kind = K_SPI;    w_arg = 12'h08D;                end
            5'd8:  begin w_kind = K_SPI;    w_arg = 12'h014;                end
            5'd9:  begin w_kind = K_SPI;    w_arg = 12'h0D9;                end
            5'd10: begin w_kind = K_SPI;    w_arg = 12'h0F1;                end
            5'd11: begin w_kind = K_PIN;    w_arg = {9'd0, 1'b0, PIN_VBAT}; end
            5'd12: begin w_kind = K_DLY;    w_arg = T_VBAT_MS;              end
            5'd13: begin w_kind = K_SPI;    w_arg = 12'h0A1;                end
            5'd14: begin w_kind = K_SPI;    w_arg = 12'h0C8;                end
            5'd15: begin w_kind = K_SPI;    w_arg = 12'h0DA;                end
            5'd16: begin w_kind = K_SPI;    w_arg = 12'h020;                end
            5'd17: begin w_kind = K_SPI;    w_arg = 12'h0AF;                end
            5'd18: begin w_kind = K_END_ON;                                 end
            5'd19: begin w_kind = K_SPI;    w_arg = 12'h0AE;                end
            5'd20: begin w_kind = K_PIN;    w_arg = {9'd0, 1'b1, PIN_VBAT}; end
            5'd21: begin w_kind = K_DLY;    w_arg = T_VBAT_MS;              end
            5'd22: begin w_kind = K_PIN;    w_arg = {9'd0, 1'b1, PIN_VDD};  end
            default: begin w_kind = K_END_OFF;                              end
        endcase
    end

    // State register, step pointer, pending-off flag and first-wait-cycle marker
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_OFF;
            r_step       <= '0;
            r_pend_off   <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_step       <= w_step_nxt;
            r_pend_off   <= w_pend_off_nxt;
            r_wait_first <= (r_state == S_DLY_REQ) || (r_state == S_SPI_REQ);
        end
    end

    // Next-state logic: table walk, handshakes and on/off request handling
    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_pend_off_nxt = r_pend_off;

        // Off request during power-up is remembered until ON is reached
        if (power_off_req && (r_state != S_OFF) && (r_state != S_ON) && (r_step < STEP_DOWN))
            w_pend_off_nxt = 1'b1;

        case (r_state)
            S_OFF: begin
                if (power_on_req) begin
                    w_state_nxt    = S_FETCH;
                    w_step_nxt     = '0;
                    w_pend_off_nxt = power_off_req;
                end
            end
            S_FETCH: begin
                case (w_kind)
                    K_PIN:    w_step_nxt = r_step + STEP_W'(1);
                    K_DLY:    if (delay_done) w_state_nxt = S_DLY_REQ;
                    K_SPI:    if (spi_done)   w_state_nxt = S_SPI_REQ;
                    K_END_ON: w_state_nxt = S_ON;
                    default: begin
                        w_state_nxt = S_OFF;
                        w_step_nxt  = '0;
                    end
                endcase
            end
            S_DLY_REQ: w_state_nxt = S_DLY_WAIT;
            S_DLY_WAIT: begin
                if (!r_wait_first && delay_done) begin
                    w_state_nxt = S_FETCH;
                    w_step_nxt  = r_step + STEP_W'(1);
                end
            end
            S_SPI_REQ: w_state_nxt = S_SPI_WAIT;
            S_SPI_WAIT: begin
                if (!r_wait_first && spi_done) begin
                    w_state_nxt = S_FETCH;
                    w_step_nxt  = r_step + STEP_W'(1);
                end
            end
            S_ON: begin
                if (r_pend_off || power_off_req) begin
                    w_state_nxt    = S_FETCH;
                    w_step_nxt     = STEP_DOWN;
                    w_pend_off_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
                w_step_nxt  = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        w_delay_start_nxt   = 1'b0;
        w_delay_time_ms_nxt = r_delay_time_ms;
        w_spi_start_nxt     = 1'b0;
        w_spi_data_nxt      = r_spi_data;
        w_vdd_n_nxt         = r_vdd_n;
        w_vbat_n_nxt        = r_vbat_n;
        w_res_n_nxt         = r_res_n;
        w_ready_nxt         = (w_state_nxt == S_ON);

        if ((r_state == S_FETCH) && (w_state_nxt == S_DLY_REQ)) begin
            w_delay_start_nxt   = 1'b1;
            w_delay_time_ms_nxt = w_arg;
        end
        if ((r_state == S_FETCH) && (w_state_nxt == S_SPI_REQ)) begin
            w_spi_start_nxt = 1'b1;
            w_spi_data_nxt  = w_arg[7:0];
        end
        if ((r_state == S_FETCH) && (w_kind == K_PIN)) begin
            case (w_arg[1:0])
                PIN_VDD:  w_vdd_n_nxt  = w_arg[2];
                PIN_RES:  w_res_n_nxt  = w_arg[2];
                PIN_VBAT: w_vbat_n_nxt = w_arg[2];
                default:  ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_delay_start   <= 1'b0;
            r_delay_time_ms <= '0;
            r_spi_start     <= 1'b0;
            r_spi_data      <= '0;
            r_vdd_n         <= 1'b1;
            r_vbat_n        <= 1'b1;
            r_res_n         <= 1'b1;
            r_ready         <= 1'b0;
        end else begin
            r_delay_start   <= w_delay_start_nxt;
            r_delay_time_ms <= w_delay_time_ms_nxt;
            r_spi_start     <= w_spi_start_nxt;
            r_spi_data      <= w_spi_data_nxt;
            r_vdd_n         <= w_vdd_n_nxt;
            r_vbat_n        <= w_vbat_n_nxt;
            r_res_n         <= w_res_n_nxt;
            r_ready         <= w_ready_nxt;
        end
    end

    assign delay_start   = r_delay_start;
    assign delay_time_ms = r_delay_time_ms;
    assign spi_start     = r_spi_start;
    assign spi_data      = r_spi_data;
    assign vdd_n         = r_vdd_n;
    assign vbat_n        = r_vbat_n;
    assign res_n         = r_res_n;
    assign ready         = r_ready;
    // All transfers are commands, so D/C stays low
    assign dc            = 1'b0;

endmodule

// File: tb/tb_oled_power_seq.sv
// Scoreboard bench for oled_power_seq with delay and SPI responder models.
module tb_oled_power_seq;

    localparam int CYC_PER_MS = 8;
    localparam int SPI_CYC    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        power_on_req = 1'b0;
    logic        power_off_req = 1'b0;
    logic        delay_start;
    logic [11:0] delay_time_ms;
    logic        delay_done;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_done;
    logic        vdd_n, vbat_n, res_n, dc, ready;

    logic        hold_dly_low = 1'b0;
    int          dly_cnt;
    int          spi_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;

    int          spi_q[$];
    int          dly_q[$];
    int          pin_q[$];

    int          n_dly_pulses = 0;
    int          dly_len = 0;
    int          spi_len = 0;
    logic        p_vdd, p_res, p_vbat;

    oled_power_seq dut (
        .clk           (clk),
        .rst           (rst),
        .power_on_req  (power_on_req),
        .power_off_req (power_off_req),
        .delay_start   (delay_start),
        .delay_time_ms (delay_time_ms),
        .delay_done    (delay_done),
        .spi_start     (spi_start),
        .spi_data      (spi_data),
        .spi_done      (spi_done),
        .vdd_n         (vdd_n),
        .vbat_n        (vbat_n),
        .res_n         (res_n),
        .dc            (dc),
        .ready         (ready)
    );

    always #5 clk = ~clk;

    // Responders: busy for N ms (scaled) or SPI_CYC cycles after a start pulse
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt <= 0;
            spi_cnt <= 0;
        end else begin
            if (delay_start)      dly_cnt <= int'(delay_time_ms) * CYC_PER_MS;
            else if (dly_cnt > 0) dly_cnt <= dly_cnt - 1;
            if (spi_start)        spi_cnt <= SPI_CYC;
            else if (spi_cnt > 0) spi_cnt <= spi_cnt - 1;
        end
    end
    assign delay_done = (dly_cnt == 0) && !delay_start && !hold_dly_low;
    assign spi_done   = (spi_cnt == 0) && !spi_start;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Pin event codes: pin*2 + new level (vdd=0, res=1, vbat=2)
    task automatic push_powerup();
        int b[10] = '{'hAE, 'h8D, 'h14, 'hD9, 'hF1, 'hA1, 'hC8, 'hDA, 'h20, 'hAF};
        foreach (b[i]) spi_q.push_back(b[i]);
        dly_q.push_back(1); dly_q.push_back(1); dly_q.push_back(1); dly_q.push_back(100);
        pin_q.push_back(0); pin_q.push_back(2); pin_q.push_back(3); pin_q.push_back(4);
    endtask

    task automatic push_powerdown();
        spi_q.push_back('hAE);
        dly_q.push_back(100);
        pin_q.push_back(5); pin_q.push_back(1);
    endtask

    task automatic pin_event(input int code);
        if (pin_q.size() == 0) check_val("pin_unexpected", 32'(code), 32'hFF);
        else check_val("pin_order", 32'(code), 32'(pin_q.pop_front()));
    endtask

    // Monitor: pops scoreboard entries as the DUT produces requests and pin edges
    always @(negedge clk) begin
        if (rst) begin
            p_vdd = vdd_n; p_res = res_n; p_vbat = vbat_n;
            dly_len = 0; spi_len = 0;
        end else begin
            if (delay_start) begin
                dly_len++;
                if (dly_len == 1) begin
                    n_dly_pulses++;
                    if (dly_q.size() == 0) check_val("dly_unexpected", 32'(delay_time_ms), 32'hFFFF);
                    else check_val("dly_ms", 32'(delay_time_ms), 32'(dly_q.pop_front()));
                end
            end else if (dly_len != 0) begin
                check_val("dly_pulse_len", 32'(dly_len), 32'd1);
                dly_len = 0;
            end
            if (spi_start) begin
                spi_len++;
                if (spi_len == 1) begin
                    if (spi_q.size() == 0) check_val("spi_unexpected", 32'(spi_data), 32'hFFFF);
                    else check_val("spi_byte", 32'(spi_data), 32'(spi_q.pop_front()));
                end
            end else if (spi_len != 0) begin
                check_val("spi_pulse_len", 32'(spi_len), 32'd1);
                spi_len = 0;
            end
            if (vdd_n  !== p_vdd)  pin_event(0 + int'(vdd_n));
            if (res_n  !== p_res)  pin_event(2 + int'(res_n));
            if (vbat_n !== p_vbat) pin_event(4 + int'(vbat_n));
            p_vdd = vdd_n; p_res = res_n; p_vbat = vbat_n;
        end
    end

    task automatic pulse_on(input logic with_off);
        @(negedge clk);
        power_on_req  = 1'b1;
        power_off_req = with_off;
        @(negedge clk);
        power_on_req  = 1'b0;
        power_off_req = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!ready && k < 5000) begin @(negedge clk); k++; end
        if (!ready) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_empty(input string tag);
        check_val({tag, "_spi_left"}, 32'(spi_q.size()), 32'd0);
        check_val({tag, "_dly_left"}, 32'(dly_q.size()), 32'd0);
        check_val({tag, "_pin_left"}, 32'(pin_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_vdd_n"},  32'(vdd_n), 32'd1);
        check_val({tag, "_vbat_n"}, 32'(vbat_n), 32'd1);
        check_val({tag, "_res_n"},  32'(res_n), 32'd1);
        check_val({tag, "_dc"},     32'(dc), 32'd0);
        check_val({tag, "_ready"},  32'(ready), 32'd0);
        check_val({tag, "_dstart"}, 32'(delay_start), 32'd0);
        check_val({tag, "_sstart"}, 32'(spi_start), 32'd0);
        check_val({tag, "_dtime"},  32'(delay_time_ms), 32'd0);
        check_val({tag, "_sdata"},  32'(spi_data), 32'd0);
    endtask

    initial begin
        int k;
        int ready_cyc;
        int base;
        bit seen_fall;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        #2 rst = 1'b0;

        // Full power-up
        push_powerup();
        pulse_on(1'b0);
        wait_ready("up");
        check_val("up_spi_done_at_ready", 32'(spi_done), 32'd1);
        check_empty("up");
        check_val("up_dtime_hold", 32'(delay_time_ms), 32'd100);
        check_val("up_sdata_hold", 32'(spi_data), 32'hAF);
        repeat (5) @(negedge clk);
        check_val("up_ready_stays", 32'(ready), 32'd1);
        check_val("up_dc", 32'(dc), 32'd0);

        // Power-down from ON
        push_powerdown();
        power_off_req = 1'b1;
        @(negedge clk);
        power_off_req = 1'b0;
        check_val("down_ready_fall", 32'(ready), 32'd0);
        k = 0;
        while (!vdd_n && k < 3000) begin @(negedge clk); k++; end
        check_val("down_vdd_off", 32'(vdd_n), 32'd1);
        repeat (20) @(negedge clk);
        check_empty("down");
        check_val("down_stays_off", 32'(vbat_n & vdd_n & !ready), 32'd1);

        // Off request during VBAT delay: one-cycle ready pulse then power-down
        push_powerup();
        push_powerdown();
        pulse_on(1'b0);
        k = 0;
        while (!(delay_start && delay_time_ms == 12'd100) && k < 5000) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        power_off_req = 1'b1;
        @(negedge clk);
        power_off_req = 1'b0;
        ready_cyc = 0; seen_fall = 0; k = 0;
        while (!(seen_fall && vdd_n) && k < 5000) begin
            @(negedge clk);
            if (ready) ready_cyc++;
            if (ready_cyc > 0) seen_fall = 1;
            k++;
        end
        check_val("pend_ready_len", 32'(ready_cyc), 32'd1);
        check_val("pend_vdd_off", 32'(vdd_n), 32'd1);
        repeat (5) @(negedge clk);
        check_empty("pend");

        // Both requests together in OFF: up then straight down
        push_powerup();
        push_powerdown();
        pulse_on(1'b1);
        ready_cyc = 0; seen_fall = 0; k = 0;
        while (!(seen_fall && vdd_n) && k < 5000) begin
            @(negedge clk);
            if (ready) ready_cyc++;
            if (!vdd_n) seen_fall = 1;
            k++;
        end
        check_val("both_ready_len", 32'(ready_cyc), 32'd1);
        repeat (5) @(negedge clk);
        check_empty("both");

        // Delay responder busy: stall in FETCH with no delay_start
        hold_dly_low = 1'b1;
        push_powerup();
        base = n_dly_pulses;
        pulse_on(1'b0);
        repeat (40) @(negedge clk);
        check_val("stall_no_pulse", 32'(n_dly_pulses - base), 32'd0);
        check_val("stall_vdd_on", 32'(vdd_n), 32'd0);
        hold_dly_low = 1'b0;
        repeat (6) @(negedge clk);
        check_val("stall_one_pulse", 32'(n_dly_pulses - base), 32'd1);

        // Async reset during SPI_WAIT of the first command
        k = 0;
        while (!spi_start && k < 200) begin @(negedge clk); k++; end
        check_val("rst_saw_spi", 32'(spi_start), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        spi_q.delete(); dly_q.delete(); pin_q.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Restart from step 0 after reset
        push_powerup();
        pulse_on(1'b0);
        wait_ready("restart");
        check_empty("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
